video_timing: RTL
=================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 H_ACTIVE, default 640, visible pixels per line.
REQ-002 H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 H_BACK, default 48, horizontal back porch in pixels.
REQ-005 V_ACTIVE, default 480, visible lines per frame.
REQ-006 V_FRONT, default 10, vertical front porch in lines.
REQ-007 V_SYNC, default 2, vertical sync width in lines.
REQ-008 V_BACK, default 33, vertical back porch in lines.
REQ-009 SYNC_POL, default 0, active level of hsync and vsync; 0 means active-low.
REQ-010 pixel_clk  input  1  pixel clock; the only clock; all state updates on its rising edge.
REQ-011 reset_n  input  1  asynchronous, active-low reset.
REQ-012 counterX  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-013 counterY  output  10  current vertical position, 0..V_TOTAL-1.
REQ-014 de  output  1  active-video flag for the current (counterX, counterY).
REQ-015 hsync, vsync  output  1 each  sync for the current position, at SYNC_POL level when active.
REQ-016 de_d, hsync_d, vsync_d  output  1 each  de/hsync/vsync delayed by exactly 1 cycle, aligned with the registered colour stage downstream.
REQ-017 line_start  output  1  single-cycle pulse while counterX==0.
REQ-018 frame_start  output  1  single-cycle pulse while counterX==0 and counterY==0.
REQ-019 frame_count  output  8  number of completed frames, modulo 256.

Function
REQ-020 H_TOTAL SHALL be H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL SHALL be V_ACTIVE+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-021 counterX SHALL increment by 1 every cycle and wrap from H_TOTAL-1 to 0.
REQ-022 counterY SHALL increment only in the cycle where counterX wraps, and SHALL wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-023 At (H_TOTAL-1, V_TOTAL-1), both counters SHALL wrap simultaneously to (0,0), and frame_count SHALL increment in the same edge, wrapping 255->0.
REQ-024 de SHALL be 1 iff counterX<H_ACTIVE and counterY<V_ACTIVE; it is combinational from the counter registers, with zero latency.
REQ-025 hsync SHALL be active iff H_ACTIVE+H_FRONT <= counterX < H_ACTIVE+H_FRONT+H_SYNC (default 656..751).
REQ-026 vsync SHALL be active iff V_ACTIVE+V_FRONT <= counterY < V_ACTIVE+V_FRONT+V_SYNC (default 490..491) for the whole of each such line.
REQ-027 de_d, hsync_d and vsync_d SHALL be registered copies of de, hsync and vsync with exactly 1 cycle of latency.
REQ-028 line_start and frame_start SHALL be decoded from the counter registers and be high for exactly one cycle per line or frame.
REQ-029 All counter arithmetic SHALL be unsigned 10-bit; the counters SHALL never hold a value >= H_TOTAL or >= V_TOTAL.

Reset
REQ-030 While reset_n is low: counterX=0, counterY=0, frame_count=0, de_d=0, and hsync_d/vsync_d at the inactive level (!SYNC_POL).
REQ-031 Reset assertion mid-frame SHALL take effect asynchronously, with no completion of the current line or frame.
REQ-032 After reset_n deasserts, the first rising edge SHALL advance counterX from 0 to 1; frame_start is high during the first post-reset cycle.

Structure
REQ-033 The default timing constants and the derived H_TOTAL and V_TOTAL SHALL live in the shared package video_timing_pkg, which video_generator also uses.
REQ-034 The 1-cycle alignment register SHALL be a sub-module video_sync_align, parameterised by delay depth, with a default depth of 1.
REQ-035 The block SHALL contain no other sub-modules and no combinational path from input to output other than the reset.

Verification
REQ-036 Release reset and run 800 cycles -> counterX goes 0..799 then 0, and counterY goes 0->1 exactly at the wrap.
REQ-037 Run 420000 cycles -> frame_start is seen at cycles 0 and 420000 only, and frame_count = 1 after the first frame wraps.
REQ-038 Line 0 -> hsync low for cycles 656..751 only, de high for 0..639, and de_d/hsync_d equal the same waveforms shifted by 1 cycle.
REQ-039 Full frame -> vsync low only on lines 490 and 491, and de is never high for counterY >= 480.
REQ-040 Assert reset_n at (400, 300) for 3 cycles -> outputs take the reset values immediately, and counting restarts from (0,0) on release.
REQ-041 Run 256 frames with SYNC_POL=1 -> frame_count wraps to 0, and sync pulses are active-high.

Source files
------------

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Shared raster constants for the video pipeline. Holds the
//                default 640x480@60 timing, the derived line/frame totals,
//                the sync bundle type that travels through the alignment
//                stage, and a small window-decode helper.
//                Used by video_timing and video_generator.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  // Counter widths: 10 bits covers totals up to 1024 pixels/lines.
  localparam int CNT_W = 10;
  localparam int FC_W  = 8;

  // Default horizontal timing, in pixels.
  localparam int DEFAULT_H_ACTIVE = 640;
  localparam int DEFAULT_H_FRONT  = 16;
  localparam int DEFAULT_H_SYNC   = 96;
  localparam int DEFAULT_H_BACK   = 48;

  // Default vertical timing, in lines.
  localparam int DEFAULT_V_ACTIVE = 480;
  localparam int DEFAULT_V_FRONT  = 10;
  localparam int DEFAULT_V_SYNC   = 2;
  localparam int DEFAULT_V_BACK   = 33;

  // Default sync polarity: 0 = active-low.
  localparam bit DEFAULT_SYNC_POL = 1'b0;

  // Derived totals for the default timing (800 x 525).
  localparam int H_TOTAL = DEFAULT_H_ACTIVE + DEFAULT_H_FRONT
                         + DEFAULT_H_SYNC   + DEFAULT_H_BACK;
  localparam int V_TOTAL = DEFAULT_V_ACTIVE + DEFAULT_V_FRONT
                         + DEFAULT_V_SYNC   + DEFAULT_V_BACK;

  // Per-pixel control bundle that is delayed alongside the colour data.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  // Half-open window test: lo <= pos < hi, all unsigned.
  function automatic logic in_window(
    input logic [CNT_W-1:0] pos,
    input logic [CNT_W-1:0] lo,
    input logic [CNT_W-1:0] hi
  );
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_sync_align.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_align
//  Description : Fixed-latency delay line for the control bundle so that
//                de/hsync/vsync line up with the registered colour stage.
//  Ports       : clk       - pixel clock
//                rst_n     - asynchronous active-low reset
//                din       - undelayed bundle
//                dout      - bundle delayed by DEPTH cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module video_sync_align #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Reset loads the idle value so the sync outputs sit inactive
      // rather than asserted while the raster is held.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= RESET_VAL;
          end
        end else begin
          r_stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing
//  Description : Raster timing generator. Free-running horizontal/vertical
//                counters, zero-latency de/hsync/vsync decode, one-cycle
//                aligned copies, line/frame start pulses and a frame counter.
//  Ports       : pixel_clk    - pixel clock, rising-edge active
//                reset_n      - asynchronous active-low reset
//                counterX     - horizontal position 0..H_TOTAL-1
//                counterY     - vertical position 0..V_TOTAL-1
//                de           - active video at (counterX, counterY)
//                hsync/vsync  - sync at SYNC_POL level when active
//                de_d/hsync_d/vsync_d - same, delayed one cycle
//                line_start   - high while counterX == 0
//                frame_start  - high while counterX == 0 and counterY == 0
//                frame_count  - completed frames, modulo 256
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEFAULT_H_ACTIVE,
  parameter int H_FRONT  = DEFAULT_H_FRONT,
  parameter int H_SYNC   = DEFAULT_H_SYNC,
  parameter int H_BACK   = DEFAULT_H_BACK,
  parameter int V_ACTIVE = DEFAULT_V_ACTIVE,
  parameter int V_FRONT  = DEFAULT_V_FRONT,
  parameter int V_SYNC   = DEFAULT_V_SYNC,
  parameter int V_BACK   = DEFAULT_V_BACK,
  parameter bit SYNC_POL = DEFAULT_SYNC_POL
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] counterX,
  output logic [CNT_W-1:0] counterY,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             de_d,
  output logic             hsync_d,
  output logic             vsync_d,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  // --------------------------------------------------------------------------
  // Timing constants, all reduced to the counter width once here so every
  // compare below is a plain unsigned 10-bit compare.
  // --------------------------------------------------------------------------
  localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(c_h_total - 1);
  localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(c_v_total - 1);
  localparam logic [CNT_W-1:0] c_h_active   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_active   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_hs_start   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] c_hs_end     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] c_vs_start   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] c_vs_end     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // Idle bundle: no active video, both syncs at their inactive level.
  localparam logic [$bits(sync_t)-1:0] c_sync_idle = {1'b0, ~SYNC_POL, ~SYNC_POL};

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic [FC_W-1:0]  r_frame_count;

  logic w_x_last;
  logic w_y_last;

  assign w_x_last = (r_x == c_h_last);
  assign w_y_last = (r_y == c_v_last);

  // Wrap is decided by equality with the last index, so the counters can
  // never step past the total even for non-power-of-two geometries.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_x_last) begin
        r_x <= '0;
        if (w_y_last) begin
          r_y           <= '0;
          r_frame_count <= r_frame_count + FC_W'(1);
        end else begin
          r_y <= r_y + CNT_W'(1);
        end
      end else begin
        r_x <= r_x + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Zero-latency decode from the counter registers
  // --------------------------------------------------------------------------
  logic w_de;
  logic w_hs_act;
  logic w_vs_act;

  assign w_de     = (r_x < c_h_active) && (r_y < c_v_active);
  assign w_hs_act = in_window(r_x, c_hs_start, c_hs_end);
  // vsync depends only on the line number, so it spans whole lines.
  assign w_vs_act = in_window(r_y, c_vs_start, c_vs_end);

  sync_t w_sync_now;
  sync_t w_sync_dly;

  always_comb begin
    w_sync_now       = '0;
    w_sync_now.de    = w_de;
    w_sync_now.hsync = w_hs_act ? SYNC_POL : ~SYNC_POL;
    w_sync_now.vsync = w_vs_act ? SYNC_POL : ~SYNC_POL;
  end

  // --------------------------------------------------------------------------
  // One-cycle alignment with the downstream colour register
  // --------------------------------------------------------------------------
  video_sync_align #(
    .WIDTH     ($bits(sync_t)),
    .DEPTH     (1),
    .RESET_VAL (c_sync_idle)
  ) u_sync_align (
    .clk   (pixel_clk),
    .rst_n (reset_n),
    .din   (w_sync_now),
    .dout  (w_sync_dly)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign counterX    = r_x;
  assign counterY    = r_y;
  assign frame_count = r_frame_count;

  assign de          = w_sync_now.de;
  assign hsync       = w_sync_now.hsync;
  assign vsync       = w_sync_now.vsync;

  assign de_d        = w_sync_dly.de;
  assign hsync_d     = w_sync_dly.hsync;
  assign vsync_d     = w_sync_dly.vsync;

  assign line_start  = (r_x == '0);
  assign frame_start = (r_x == '0) && (r_y == '0);

endmodule
`default_nettype wire
